// File: rtl/pic_pkg.sv
// Shared constants for the interrupt controller: channel limits, trigger-mode encodings,
// and the default synchroniser depth.
package pic_pkg;

  localparam int   PIC_MAX_IRQ     = 32;
  localparam int   PIC_SYNC_STAGES = 2;
  localparam logic TRIG_EDGE       = 1'b0;
  localparam logic TRIG_LEVEL      = 1'b1;

endpackage

// File: rtl/irq_sync.sv
// Multi-bit pin synchroniser with STAGES flops per bit, reset to zero.
// Latency is STAGES cycles. There is no backpressure; it samples every cycle.
module irq_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;
  logic [STAGES-1:0][WIDTH-1:0] stage_d;

  always_comb begin
    stage_d[0] = async_in;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign sync_out = stage_q[STAGES-1];

endmodule

// File: rtl/irq_request_register_sync.sv
// Interrupt request register that takes per-channel edge or level triggers, with freeze and overrun flags.
// A pin reaches the output SYNC_STAGES+1 cycles later and a clear takes 1 cycle; there is no backpressure.
module irq_request_register_sync
  import pic_pkg::*;
#(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = PIC_SYNC_STAGES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] ir_req_pin,
  input  logic [NUM_IRQ-1:0] trigger_mode,
  input  logic [NUM_IRQ-1:0] clear_ir_line,
  input  logic               freeze,
  input  logic [NUM_IRQ-1:0] clear_overrun,
  output logic [NUM_IRQ-1:0] interrupt_req_reg,
  output logic [NUM_IRQ-1:0] overrun
);

  logic [NUM_IRQ-1:0] sync_q;

  irq_sync #(
    .WIDTH  (NUM_IRQ),
    .STAGES (SYNC_STAGES)
  ) u_irq_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (ir_req_pin),
    .sync_out (sync_q)
  );

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_ch
    logic prev_q, prev_d;
    logic edge_q, edge_d;
    logic irr_q, irr_d;
    logic ovf_q, ovf_d;
    logic rise, live;

    // prev_q tracks in both modes, so a level-to-edge switch with the pin high raises nothing.
    always_comb begin
      prev_d = sync_q[g];
      rise   = sync_q[g] & ~prev_q;
      edge_d = 1'b0;
      live   = 1'b0;
      ovf_d  = ovf_q & ~clear_overrun[g];
      if (trigger_mode[g] == TRIG_LEVEL) begin
        live = sync_q[g] & ~clear_ir_line[g];
      end else begin
        edge_d = (edge_q & ~clear_ir_line[g]) | rise;
        live   = edge_d;
        ovf_d  = ovf_d | (rise & edge_q & ~clear_ir_line[g]);
      end
      irr_d = freeze ? (irr_q & ~clear_ir_line[g]) : live;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        prev_q <= 1'b0;
        edge_q <= 1'b0;
        irr_q  <= 1'b0;
        ovf_q  <= 1'b0;
      end else begin
        prev_q <= prev_d;
        edge_q <= edge_d;
        irr_q  <= irr_d;
        ovf_q  <= ovf_d;
      end
    end

    assign interrupt_req_reg[g] = irr_q;
    assign overrun[g]           = ovf_q;
  end

endmodule

// File: tb/tb_irq_request_register_sync.sv
// Testbench for irq_request_register_sync with N=8 and S=2: directed scenarios, then randomized traffic
// checked against a pin-history reference model.
module tb_irq_request_register_sync;

  localparam int N = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] pin, mode, clr, co, irr, ovf;
  logic         freeze;

  int errors = 0;
  int checks = 0;

  irq_request_register_sync #(.NUM_IRQ(N), .SYNC_STAGES(S)) dut (
    .clk               (clk),
    .reset             (reset),
    .ir_req_pin        (pin),
    .trigger_mode      (mode),
    .clear_ir_line     (clr),
    .freeze            (freeze),
    .clear_overrun     (co),
    .interrupt_req_reg (irr),
    .overrun           (ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    pin = '0; mode = '0; clr = '0; co = '0; freeze = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (irr !== 8'h00) begin errors++; $display("FAIL reset_irr got=%h exp=00", irr); end
    checks++; if (ovf !== 8'h00) begin errors++; $display("FAIL reset_ovf got=%h exp=00", ovf); end
  endtask

  task automatic test_edge_basic();
    do_reset();
    pin = 8'h08;
    step(); step();
    checks++; if (irr !== 8'h00) begin errors++; $display("FAIL edge_edge2 got=%h exp=00", irr); end
    step();
    checks++; if (irr !== 8'h08) begin errors++; $display("FAIL edge_edge3 got=%h exp=08", irr); end
    pin = 8'h00;
    step(); step(); step();
    checks++; if (irr !== 8'h08) begin errors++; $display("FAIL edge_hold got=%h exp=08", irr); end
    clr = 8'h08;
    step();
    clr = 8'h00;
    checks++; if (irr !== 8'h00) begin errors++; $display("FAIL edge_clear got=%h exp=00", irr); end
    step();
    checks++; if (irr !== 8'h00) begin errors++; $display("FAIL edge_clear_stays got=%h exp=00", irr); end
  endtask

  task automatic test_level();
    int first = -1;
    int cnt   = 0;
    do_reset();
    mode = 8'hFF;
    pin  = 8'h20;
    for (int e = 1; e <= 16; e++) begin
      step();
      if (e == 10) pin = 8'h00;
      if (irr[5]) begin
        cnt++;
        if (first < 0) first = e;
      end
    end
    checks++; if (cnt != 10) begin errors++; $display("FAIL level_width got=%0d exp=10", cnt); end
    checks++; if (first != 3) begin errors++; $display("FAIL level_delay got=%0d exp=3", first); end
    pin = 8'h20;
    repeat (5) step();
    checks++; if (irr !== 8'h20) begin errors++; $display("FAIL level_high got=%h exp=20", irr); end
    clr = 8'h20;
    step();
    clr = 8'h00;
    checks++; if (irr !== 8'h00) begin errors++; $display("FAIL level_clear got=%h exp=00", irr); end
    step();
    checks++; if (irr !== 8'h20) begin errors++; $display("FAIL level_return got=%h exp=20", irr); end
    pin = 8'h00;
    repeat (4) step();
    checks++; if (irr !== 8'h00) begin errors++; $display("FAIL level_fall got=%h exp=00", irr); end
  endtask

  task automatic test_freeze();
    do_reset();
    pin = 8'h01;
    repeat (3) step();
    pin = 8'h00;
    checks++; if (irr !== 8'h01) begin errors++; $display("FAIL frz_pre got=%h exp=01", irr); end
    freeze = 1'b1;
    pin = 8'h40;
    repeat (4) step();
    checks++; if (irr !== 8'h01) begin errors++; $display("FAIL frz_hold got=%h exp=01", irr); end
    clr = 8'h01;
    step();
    clr = 8'h00;
    checks++; if (irr !== 8'h00) begin errors++; $display("FAIL frz_clear got=%h exp=00", irr); end
    step();
    checks++; if (irr !== 8'h00) begin errors++; $display("FAIL frz_clear_hold got=%h exp=00", irr); end
    freeze = 1'b0;
    step();
    checks++; if (irr !== 8'h40) begin errors++; $display("FAIL frz_release got=%h exp=40", irr); end
    pin = 8'h00;
  endtask

  task automatic test_overrun();
    do_reset();
    pin = 8'h04; step(); step();
    pin = 8'h00; step(); step();
    pin = 8'h04; step(); step();
    pin = 8'h00;
    repeat (4) step();
    checks++; if (ovf !== 8'h04) begin errors++; $display("FAIL ovr_set got=%h exp=04", ovf); end
    checks++; if (irr !== 8'h04) begin errors++; $display("FAIL ovr_irr got=%h exp=04", irr); end
    co = 8'h04;
    step();
    co = 8'h00;
    checks++; if (ovf !== 8'h00) begin errors++; $display("FAIL ovr_clear got=%h exp=00", ovf); end
    pin = 8'h04;
    step(); step();
    clr = 8'h04;
    step();
    clr = 8'h00;
    checks++; if (irr !== 8'h04) begin errors++; $display("FAIL ovr_coinc_irr got=%h exp=04", irr); end
    checks++; if (ovf !== 8'h00) begin errors++; $display("FAIL ovr_coinc_ovf got=%h exp=00", ovf); end
    step();
    checks++; if (irr !== 8'h04) begin errors++; $display("FAIL ovr_coinc_hold got=%h exp=04", irr); end
    pin = 8'h00;
  endtask

  task automatic test_mode_switch();
    do_reset();
    mode = 8'h02;
    pin  = 8'h02;
    repeat (4) step();
    checks++; if (irr !== 8'h02) begin errors++; $display("FAIL ms_level got=%h exp=02", irr); end
    mode = 8'h00;
    repeat (4) step();
    checks++; if (irr !== 8'h00) begin errors++; $display("FAIL ms_no_spurious got=%h exp=00", irr); end
    pin = 8'h00;
    repeat (2) step();
    pin = 8'h02;
    step(); step();
    checks++; if (irr !== 8'h00) begin errors++; $display("FAIL ms_early got=%h exp=00", irr); end
    step();
    checks++; if (irr !== 8'h02) begin errors++; $display("FAIL ms_reraise got=%h exp=02", irr); end
    pin = 8'h00;
  endtask

  task automatic test_reset_mid();
    do_reset();
    pin = 8'hFF;
    repeat (3) step();
    pin = 8'hF0; step(); step();
    pin = 8'hFF;
    repeat (4) step();
    checks++; if (irr !== 8'hFF) begin errors++; $display("FAIL rm_pre_irr got=%h exp=FF", irr); end
    checks++; if (ovf !== 8'h0F) begin errors++; $display("FAIL rm_pre_ovf got=%h exp=0F", ovf); end
    freeze = 1'b1;
    clr    = 8'hAA;
    reset  = 1'b1;
    step();
    checks++; if (irr !== 8'h00) begin errors++; $display("FAIL rm_irr got=%h exp=00", irr); end
    checks++; if (ovf !== 8'h00) begin errors++; $display("FAIL rm_ovf got=%h exp=00", ovf); end
    reset  = 1'b0;
    freeze = 1'b0;
    clr    = 8'h00;
    step(); step();
    checks++; if (irr !== 8'h00) begin errors++; $display("FAIL rm_edge2 got=%h exp=00", irr); end
    step();
    checks++; if (irr !== 8'hFF) begin errors++; $display("FAIL rm_edge3 got=%h exp=FF", irr); end
    pin = 8'h00;
  endtask

  // Reference model: the synchronised view of a pin is simply the value sampled S edges earlier.
  task automatic test_random();
    logic [N-1:0] hist[$];
    logic [N-1:0] m_edge, m_irr, m_ovf, sync_v, prev_v, rise, live;
    do_reset();
    m_edge = '0; m_irr = '0; m_ovf = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      pin = pin ^ (N'($urandom) & N'($urandom));
      if ($urandom_range(0, 31) == 0) mode = N'($urandom);
      if ($urandom_range(0, 7) == 0) freeze = ~freeze;
      clr   = ($urandom_range(0, 3) == 0) ? (N'($urandom) & N'($urandom)) : '0;
      co    = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      reset = ($urandom_range(0, 99) == 0);

      sync_v = (hist.size() >= S)     ? hist[hist.size()-S]   : '0;
      prev_v = (hist.size() >= S + 1) ? hist[hist.size()-S-1] : '0;
      rise   = sync_v & ~prev_v;
      if (reset) begin
        m_edge = '0; m_irr = '0; m_ovf = '0;
        hist.delete();
      end else begin
        m_ovf  = (m_ovf & ~co) | (rise & m_edge & ~clr & ~mode);
        m_edge = ((m_edge & ~clr) | rise) & ~mode;
        live   = (mode & sync_v & ~clr) | (~mode & m_edge);
        m_irr  = freeze ? (m_irr & ~clr) : live;
        hist.push_back(pin);
      end
      step();
      checks++; if (irr !== m_irr) begin errors++; $display("FAIL rnd_irr cyc=%0d got=%h exp=%h", cyc, irr, m_irr); end
      checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL rnd_ovf cyc=%0d got=%h exp=%h", cyc, ovf, m_ovf); end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    pin = '0; mode = '0; clr = '0; co = '0; freeze = 1'b0;
    test_reset();
    test_edge_basic();
    test_level();
    test_freeze();
    test_overrun();
    test_mode_switch();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_request_register_sync.md
# irq_request_register_sync

Parametrised, clocked successor to the 8259A interrupt request register (IRR). It synchronises `NUM_IRQ` asynchronous request pins and applies a trigger mode chosen per channel: edge requests latch until cleared, level requests follow the pin. It holds a stable IRR snapshot while `freeze` is asserted, without losing edges that arrive during the freeze. It flags per-channel overrun when a second edge arrives before the first is serviced. It sits between the IR pins and the priority resolver / in-service logic.

## Interface
- `NUM_IRQ`, 8: number of request channels (1..32).
- `SYNC_STAGES`, 2: flip-flops in each pin synchroniser (2..4).
- `clk` input 1: single clock for all state.
- `reset` input 1: synchronous, active-high reset.
- `ir_req_pin` input NUM_IRQ: asynchronous request pins from I/O devices.
- `trigger_mode` input NUM_IRQ: per-channel mode; 1 = level, 0 = rising edge.
- `clear_ir_line` input NUM_IRQ: one-hot or multi-hot clear from control logic (INTA / service).
- `freeze` input 1: hold IRR output (INTA sequence in progress).
- `clear_overrun` input NUM_IRQ: clear the sticky overrun bits.
- `interrupt_req_reg` output NUM_IRQ: registered IRR to the priority resolver.
- `overrun` output NUM_IRQ: sticky flag, set when an edge is lost.

## Operation
- Per channel: `sync_q` = last synchroniser stage; `prev_q` = `sync_q` delayed one cycle; `rise` = `sync_q & ~prev_q`.
- Edge latch:
  - Edge channel: `edge_d = (edge_q & ~clear_ir_line) | rise`.
  - Level channel: `edge_d` = 0, so the latch is held cleared.
  - A rise coincident with a clear sets the bit. The new event wins.
- IRR register:
  - Freeze low: `interrupt_req_reg <= trigger_mode ? sync_q : edge_d`.
  - Freeze high: `interrupt_req_reg <= interrupt_req_reg & ~clear_ir_line`. Clear overrides freeze; nothing else changes the output.
- During freeze, `edge_q` keeps capturing. Captured edges appear on the first non-frozen update.
- Overrun (edge channels only): `ovf_d = (ovf_q & ~clear_overrun) | (rise & edge_q & ~clear_ir_line)`. Set wins over `clear_overrun` in the same cycle. Level channels never set overrun.
- Mode switch:
  - Level to edge: no spurious edge, because `prev_q` tracks continuously. A pin already high produces no request until it falls and rises again.
  - Edge to level: the latch clears on the next edge.
- Reset: synchroniser, `prev_q`, `edge_q`, `interrupt_req_reg` and `overrun` all go to 0. A pin held high through reset release counts as a rising edge.

## Timing
- Pin change to output: the pin is sampled at clock edge 1. `interrupt_req_reg` reflects it at edge `SYNC_STAGES+1`. This is the same for both modes.
- Clear to output: `interrupt_req_reg` bit low at the clock edge where `clear_ir_line` is sampled, i.e. 1 cycle.
- Clear on a level channel with the pin still high: the bit is low for one cycle, then returns to 1. Level clear has no lasting effect.
- Freeze release to output: the first clock edge with `freeze` low loads the live value.
- Pin pulses shorter than one clock period may be missed. The requirement is a pulse of at least one period high and one period low between edges.
- Reset mid-operation: all state is zero one cycle after `reset` is sampled high, regardless of `freeze` or clear inputs.

## Structure
- Shared package `pic_pkg`:
  - `PIC_MAX_IRQ` = 32.
  - Mode encodings `TRIG_EDGE` = 0, `TRIG_LEVEL` = 1.
  - Default `SYNC_STAGES`.
- Sub-module `irq_sync`: parametrised N-bit, `SYNC_STAGES`-deep reset-to-zero synchroniser. It is instantiated once for the whole vector.
- Top level holds the edge detect, latch, freeze, IRR and overrun logic in one generate loop per channel.

## Test plan
- Edge basic (N=8, S=2), all edge: pulse `ir_req_pin[3]` high.
  - `interrupt_req_reg` = 0x08 at edge 3.
  - Stays 0x08 after the pin drops.
  - `clear_ir_line` = 0x08 gives 0x00 next edge.
- Level: `trigger_mode` = 0xFF, raise pin 5 for 10 cycles.
  - Output bit 5 is high for 10 cycles, delayed 3 cycles from the pin.
  - A clear mid-pulse drops it for exactly one cycle.
- Freeze:
  - Output 0x01, then `freeze`=1, then edge on pin 6: output stays 0x01.
  - Clear 0x01 during freeze gives 0x00.
  - Release freeze gives 0x40 next edge.
- Overrun: two edges on pin 2 with no clear.
  - `overrun` = 0x04; IRR = 0x04.
  - `clear_overrun` = 0x04 gives 0x00.
  - Edge coincident with `clear_ir_line[2]`: IRR stays 0x04, no overrun.
- Mode switch: pin 1 high in level mode, switch to edge.
  - No request.
  - Drop and re-raise the pin: request appears 3 cycles later.
- Reset: mid-operation with IRR 0xFF, overrun 0x0F, `freeze`=1 → both outputs 0x00 next edge; pins held high → IRR 0xFF at edge 3 after release (edge mode).
